// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: table geometry, counter encodings, FSM states.
// Optional statistics counters are enabled with the BPU_STATS_EN macro.
package branch_predict_unit_pkg;

  localparam int BPU_INDEX_BITS = 6;
  localparam int BPU_TAG_BITS   = 8;
  localparam int CPU_BUS_SIZE   = 32;

  localparam logic [1:0] BPU_SNT = 2'b00;
  localparam logic [1:0] BPU_WNT = 2'b01;
  localparam logic [1:0] BPU_WT  = 2'b10;
  localparam logic [1:0] BPU_ST  = 2'b11;

  typedef enum logic {
    BPU_INIT  = 1'b0,
    BPU_READY = 1'b1
  } bpu_state_e;

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// 2-bit saturating increment/decrement used when a resolved branch updates its counter.
module bpu_sat_counter
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != BPU_ST) o_ctr = i_ctr + 2'b01;
    end else begin
      if (i_ctr != BPU_SNT) o_ctr = i_ctr - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch history table with 2-bit counters and a direct-mapped target buffer beside IF.
// Define BPU_STATS_EN to build the resolved-branch and mispredict statistics counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         INDEX_BITS = BPU_INDEX_BITS,
  parameter int         TAG_BITS   = BPU_TAG_BITS,
  parameter logic [1:0] INIT_STATE = BPU_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_if_pc,
  input  logic        i_if_valid,
  output logic        o_bpu_ready,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic [1:0]  o_pred_bits,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_mispredict,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispred
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                  r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [1:0]            r_ctr    [ENTRIES];
  logic [29:0]           r_target [ENTRIES];

  bpu_state_e            r_state;
  logic [INDEX_BITS-1:0] r_ptr;
  logic                  r_ready;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_up_hit;
  logic                  w_up_en;
  logic [1:0]            w_ctr_next;
  logic                  w_unused;

  assign w_lk_idx = i_if_pc[INDEX_BITS+1:2];
  assign w_lk_tag = i_if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_up_idx = i_upd_pc[INDEX_BITS+1:2];
  assign w_up_tag = i_upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Lookup reads the table as it stood before this cycle's update edge.
  assign w_lk_hit      = (r_state == BPU_READY) && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_pred_bits   = w_lk_hit ? r_ctr[w_lk_idx] : BPU_SNT;
  assign o_pred_target = o_pred_taken ? {r_target[w_lk_idx], 2'b00} : 32'd0;
  assign o_bpu_ready   = r_ready;

  assign w_up_en  = i_upd_valid && (r_state == BPU_READY);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign w_unused = ^{i_if_valid, i_if_pc[31:INDEX_BITS+TAG_BITS+2], i_if_pc[1:0],
                      i_upd_pc[31:INDEX_BITS+TAG_BITS+2], i_upd_pc[1:0],
                      i_upd_target[1:0], i_upd_mispredict};

  bpu_sat_counter u_sat_counter (
    .i_ctr (r_ctr[w_up_idx]),
    .i_inc (i_upd_taken),
    .o_ctr (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BPU_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        BPU_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == INDEX_BITS'(ENTRIES - 1)) begin
            r_state <= BPU_READY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= BPU_READY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Table storage has no reset; the INIT sweep brings every entry to a known state.
  always_ff @(posedge clk) begin
    if (r_state == BPU_INIT) begin
      r_valid[r_ptr] <= 1'b0;
      r_ctr[r_ptr]   <= INIT_STATE;
    end else if (w_up_en) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (i_upd_taken) r_target[w_up_idx] <= i_upd_target[31:2];
      end else if (i_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd_target[31:2];
        r_ctr[w_up_idx]    <= INIT_STATE + 2'b01;
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches <= 32'd0;
      r_stat_mispred  <= 32'd0;
    end else if (w_up_en) begin
      if (r_stat_branches != 32'hFFFF_FFFF) r_stat_branches <= r_stat_branches + 32'd1;
      if (i_upd_mispredict && (r_stat_mispred != 32'hFFFF_FFFF))
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign o_stat_branches = r_stat_branches;
  assign o_stat_mispred  = r_stat_mispred;
`else
  assign o_stat_branches = 32'd0;
  assign o_stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver pushes predictions computed by a
// table-level reference model, and a negedge monitor pops and compares them.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_if_pc = 32'd0;
  logic        i_if_valid = 1'b0;
  logic        o_bpu_ready;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [1:0]  o_pred_bits;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = 32'd0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = 32'd0;
  logic        i_upd_mispredict = 1'b0;
  logic [31:0] o_stat_branches;
  logic [31:0] o_stat_mispred;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct packed {
    logic        taken;
    logic [1:0]  bits;
    logic [31:0] target;
    logic [31:0] statBranches;
    logic [31:0] statMispred;
  } expect_t;

  expect_t expQ[$];

  // Reference model: one record per table slot, outcome history kept as a plain integer 0..3.
  bit          mValid  [64];
  int          mTag    [64];
  int          mCtr    [64];
  logic [31:0] mTarget [64];
  logic [31:0] mBranches;
  logic [31:0] mMispred;

  // Ten-unit clock period; outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_if_pc          (i_if_pc),
    .i_if_valid       (i_if_valid),
    .o_bpu_ready      (o_bpu_ready),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .o_pred_bits      (o_pred_bits),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_taken      (i_upd_taken),
    .i_upd_target     (i_upd_target),
    .i_upd_mispredict (i_upd_mispredict),
    .o_stat_branches  (o_stat_branches),
    .o_stat_mispred   (o_stat_mispred)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected statistics as seen at the outputs; always zero when the feature is built out.
  function automatic logic [31:0] expBranches();
`ifdef BPU_STATS_EN
    return mBranches;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] expMispred();
`ifdef BPU_STATS_EN
    return mMispred;
`else
    return 32'd0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
    mBranches = 32'd0;
    mMispred  = 32'd0;
  endtask

  // Prediction for a fetch PC from the model's current contents.
  function automatic expect_t modelLookup(input logic [31:0] pc);
    expect_t e;
    int idx;
    bit hit;
    idx = int'(pc[7:2]);
    hit = mValid[idx] && (mTag[idx] == int'(pc[15:8]));
    e.taken        = hit && (mCtr[idx] >= 2);
    e.bits         = hit ? 2'(mCtr[idx]) : 2'b00;
    e.target       = e.taken ? mTarget[idx] : 32'd0;
    e.statBranches = expBranches();
    e.statMispred  = expMispred();
    return e;
  endfunction

  // Resolved branch: strengthen or weaken a hit, allocate a taken miss, ignore a not-taken miss.
  task automatic modelUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                             input logic misp);
    int idx;
    idx = int'(pc[7:2]);
    if (mValid[idx] && (mTag[idx] == int'(pc[15:8]))) begin
      if (taken) begin
        mCtr[idx]    = (mCtr[idx] < 3) ? mCtr[idx] + 1 : 3;
        mTarget[idx] = target & 32'hFFFF_FFFC;
      end else begin
        mCtr[idx] = (mCtr[idx] > 0) ? mCtr[idx] - 1 : 0;
      end
    end else if (taken) begin
      mValid[idx]  = 1'b1;
      mTag[idx]    = int'(pc[15:8]);
      mTarget[idx] = target & 32'hFFFF_FFFC;
      mCtr[idx]    = 2;
    end
    if (mBranches != 32'hFFFF_FFFF) mBranches = mBranches + 32'd1;
    if (misp && (mMispred != 32'hFFFF_FFFF)) mMispred = mMispred + 32'd1;
  endtask

  // One READY cycle: drive lookup and update, queue the expected prediction, advance the model.
  task automatic applyStimulus(input logic [31:0] ifPc, input logic updValid, input logic [31:0] updPc,
                               input logic updTaken, input logic [31:0] updTarget, input logic updMisp);
    i_if_pc          = ifPc;
    i_if_valid       = 1'($urandom_range(0, 1));
    i_upd_valid      = updValid;
    i_upd_pc         = updPc;
    i_upd_taken      = updTaken;
    i_upd_target     = updTarget;
    i_upd_mispredict = updMisp;
    expQ.push_back(modelLookup(ifPc));
    if (updValid) modelUpdate(updPc, updTaken, updTarget, updMisp);
    @(posedge clk);
    #1;
  endtask

  // Directed look at one PC with literal expectations, placed early in a cycle before the monitor samples.
  task automatic peek(input string name, input logic [31:0] pc, input logic expTaken,
                      input logic [1:0] expBits, input logic [31:0] expTarget);
    i_if_pc     = pc;
    i_upd_valid = 1'b0;
    #1;
    checkOutput({name, "_taken"}, 32'(o_pred_taken), 32'(expTaken));
    checkOutput({name, "_bits"}, 32'(o_pred_bits), 32'(expBits));
    checkOutput({name, "_target"}, o_pred_target, expTarget);
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Count cycles until ready while throwing taken updates at the table; they must all be ignored.
  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!o_bpu_ready && cycles < 200) begin
      cycles++;
      i_if_pc      = $urandom;
      i_upd_valid  = 1'b1;
      i_upd_pc     = 32'h40 | ($urandom & 32'h0000_00FC);
      i_upd_taken  = 1'b1;
      i_upd_target = $urandom;
      @(posedge clk);
      #1;
    end
    i_upd_valid = 1'b0;
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_0003;
    pc = pc | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    return pc;
  endfunction

  // Monitor: in READY pop one expectation per cycle; before READY every prediction must be quiet.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (o_bpu_ready) begin
        if (expQ.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL noExpectation: DUT ready with empty scoreboard at %0t", $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("predTaken", 32'(o_pred_taken), 32'(e.taken));
          checkOutput("predBits", 32'(o_pred_bits), 32'(e.bits));
          checkOutput("predTarget", o_pred_target, e.target);
          checkOutput("statBranches", o_stat_branches, e.statBranches);
          checkOutput("statMispred", o_stat_mispred, e.statMispred);
        end
      end else begin
        checkOutput("initTaken", 32'(o_pred_taken), 32'd0);
        checkOutput("initBits", 32'(o_pred_bits), 32'd0);
        checkOutput("initTarget", o_pred_target, 32'd0);
        checkOutput("initStats", o_stat_branches | o_stat_mispred, 32'd0);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed scenarios first, then randomized traffic, then reset-in-sweep and stats.
  initial begin
    int cycles;
    doReset();
    waitReady(cycles);
    checkOutput("readyCycles", 32'(cycles), 32'd64);

    for (int i = 0; i < 4; i++) applyStimulus($urandom, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
    peek("alloc", 32'h40, 1'b1, 2'b10, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    peek("satHigh", 32'h40, 1'b1, 2'b11, 32'h100);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    peek("dec1", 32'h40, 1'b1, 2'b10, 32'h100);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    peek("dec2", 32'h40, 1'b0, 2'b01, 32'h0);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    peek("dec3", 32'h40, 1'b0, 2'b00, 32'h0);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    peek("satLow", 32'h40, 1'b0, 2'b00, 32'h0);

    peek("aliasMiss", 32'h140, 1'b0, 2'b00, 32'h0);
    applyStimulus(32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0);
    peek("aliasKeep", 32'h40, 1'b0, 2'b00, 32'h0);

    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
    peek("sameBefore", 32'h40, 1'b1, 2'b10, 32'h100);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    peek("sameAfter", 32'h40, 1'b0, 2'b01, 32'h0);

    for (int i = 0; i < 3000; i++)
      applyStimulus(randPc(), 1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 1)));

    doReset();
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    doReset();
    waitReady(cycles);
    checkOutput("readyAfterMidReset", 32'(cycles), 32'd64);
    peek("clearedEntry", 32'h40, 1'b0, 2'b00, 32'h0);

    applyStimulus(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1);
    applyStimulus(32'h80, 1'b1, 32'h84, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    applyStimulus(32'h80, 1'b1, 32'h88, 1'b1, 32'h300, 1'b1);
    applyStimulus(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h88, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef BPU_STATS_EN
    checkOutput("statBranchesFinal", o_stat_branches, 32'd5);
    checkOutput("statMispredFinal", o_stat_mispred, 32'd2);
`else
    checkOutput("statBranchesFinal", o_stat_branches, 32'd0);
    checkOutput("statMispredFinal", o_stat_mispred, 32'd0);
`endif
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
